// File: rtl/aes_ccc_lock_sequencer.sv
// CCC lock supervisor and AES core reset sequencer: synchronizes both lock
// indicators, qualifies lock, holds the core in reset, and tracks lock losses.
module aes_ccc_lock_sequencer #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 256,
  parameter int RST_HOLD_CYCLES    = 16,
  parameter int CNT_W              = 8
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             fab_lock,
  input  logic             mss_lock,
  input  logic             sw_rst_req,
  input  logic             clr_status,
  output logic             core_rst_n,
  output logic             clk_ok,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] lock_loss_cnt,
  output logic             lock_lost
);

  localparam int MAX_CYC = (LOCK_STABLE_CYCLES > RST_HOLD_CYCLES) ?
                           LOCK_STABLE_CYCLES : RST_HOLD_CYCLES;
  localparam int CW = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] STAB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0] fab_sync_q, fab_sync_d;
  logic [SYNC_STAGES-1:0] mss_sync_q, mss_sync_d;
  logic                   locked_q, locked_d;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   loss_counted;

  logic                   core_rst_n_q, core_rst_n_d;
  logic                   clk_ok_q, clk_ok_d;
  logic [CNT_W-1:0]       loss_cnt_q, loss_cnt_d;
  logic                   lost_q, lost_d;

  // Synchronizer chains shift in at bit 0; the MSB is the synchronized value.
  // The AND of both chains is registered once more so the FSM sees a clean
  // single-flop "locked" term.
  always_comb begin
    fab_sync_d = {fab_sync_q[SYNC_STAGES-2:0], fab_lock};
    mss_sync_d = {mss_sync_q[SYNC_STAGES-2:0], mss_lock};
    locked_d   = fab_sync_q[SYNC_STAGES-1] & mss_sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      fab_sync_q <= '0;
      mss_sync_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      fab_sync_q <= fab_sync_d;
      mss_sync_q <= mss_sync_d;
      locked_q   <= locked_d;
    end
  end

  // State register
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; cnt is shared between STABILIZE and HOLD.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    loss_counted = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        if (locked_q) begin
          state_d = STABILIZE;
          cnt_d   = '0;
        end
      end
      STABILIZE: begin
        if (!locked_q) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STAB_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        if (!locked_q) begin
          state_d      = WAIT_LOCK;
          cnt_d        = '0;
          loss_counted = 1'b1;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RUN: begin
        // Lock loss has priority over a software reset request.
        if (!locked_q) begin
          state_d      = WAIT_LOCK;
          cnt_d        = '0;
          loss_counted = 1'b1;
        end else if (sw_rst_req) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: reset/clock-ok decoded from next state, plus status update.
  always_comb begin
    core_rst_n_d = (state_d == RUN);
    clk_ok_d     = (state_d == RUN);
    loss_cnt_d   = loss_cnt_q;
    lost_d       = lost_q;
    if (clr_status) begin
      loss_cnt_d = loss_counted ? CNT_W'(1) : '0;
      lost_d     = loss_counted;
    end else if (loss_counted) begin
      lost_d = 1'b1;
      if (loss_cnt_q != {CNT_W{1'b1}}) begin
        loss_cnt_d = loss_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      core_rst_n_q <= 1'b0;
      clk_ok_q     <= 1'b0;
      loss_cnt_q   <= '0;
      lost_q       <= 1'b0;
    end else begin
      core_rst_n_q <= core_rst_n_d;
      clk_ok_q     <= clk_ok_d;
      loss_cnt_q   <= loss_cnt_d;
      lost_q       <= lost_d;
    end
  end

  assign core_rst_n    = core_rst_n_q;
  assign clk_ok        = clk_ok_q;
  assign state         = state_q;
  assign lock_loss_cnt = loss_cnt_q;
  assign lock_lost     = lost_q;

endmodule

// File: doc/aes_ccc_lock_sequencer.md
# aes_ccc_lock_sequencer

Lock supervisor and reset sequencer for the MSS clock conditioning circuit in the AES APB subsystem. It synchronizes the CCC fabric and MSS lock indicators into the PCLK domain, qualifies lock for a programmable stable interval, and holds the AES core in reset for a fixed interval before releasing it. It also handles software-requested core resets, and records lock-loss events in a saturating counter and a sticky flag readable from the APB register file.

## Interface
- SYNC_STAGES, 2: synchronizer depth for each lock input; ≥2.
- LOCK_STABLE_CYCLES, 256: number of consecutive locked cycles required before sequencing continues; ≥1.
- RST_HOLD_CYCLES, 16: number of cycles core_rst_n is held low before release; ≥1.
- CNT_W, 8: lock-loss counter width.
- PCLK  in  1  system clock; all logic is on this clock.
- PRESETn  in  1  asynchronous active-low reset.
- fab_lock  in  1  CCC fabric lock; asynchronous to PCLK.
- mss_lock  in  1  CCC MSS lock; asynchronous to PCLK.
- sw_rst_req  in  1  single-cycle software core-reset request, synchronous.
- clr_status  in  1  single-cycle clear of lock_loss_cnt and lock_lost, synchronous.
- core_rst_n  out  1  registered active-low reset to the AES core.
- clk_ok  out  1  registered; high only in RUN.
- state  out  2  current FSM state encoding.
- lock_loss_cnt  out  CNT_W  saturating count of qualified lock losses.
- lock_lost  out  1  sticky lock-loss flag.

## Operation
- locked = fab_lock_s AND mss_lock_s, where each _s signal passes through SYNC_STAGES flops reset to 0.
- FSM states: WAIT_LOCK=0, STABILIZE=1, HOLD=2, RUN=3. A single counter `cnt` is shared between STABILIZE and HOLD; its width is clog2 of max(LOCK_STABLE_CYCLES, RST_HOLD_CYCLES)+1.
- **WAIT_LOCK:** if locked, go to STABILIZE with cnt=0.
- **STABILIZE:** if !locked, go to WAIT_LOCK; this loss is not counted. Otherwise, if cnt==LOCK_STABLE_CYCLES-1, go to HOLD with cnt=0. Otherwise cnt++.
- **HOLD:** if !locked, go to WAIT_LOCK; this loss is counted. Otherwise, if cnt==RST_HOLD_CYCLES-1, go to RUN. Otherwise cnt++.
- **RUN:** if !locked, go to WAIT_LOCK; this loss is counted. Otherwise, if sw_rst_req, go to HOLD with cnt=0; lock re-qualification is skipped.
- sw_rst_req is ignored outside RUN.
- If lock loss and sw_rst_req occur in the same RUN cycle, lock loss wins.
- Counted loss: lock_lost is set to 1; lock_loss_cnt increments and saturates at 2^CNT_W-1.
- clr_status: lock_loss_cnt and lock_lost are cleared to 0. If a counted loss occurs in the same cycle, the result is lock_loss_cnt=1 and lock_lost=1.
- core_rst_n and clk_ok are decoded from next-state and registered: both are 1 iff next state is RUN.

## Timing
- Reset values:
  - state=WAIT_LOCK
  - cnt=0
  - all synchronizer flops=0
  - core_rst_n=0
  - clk_ok=0
  - lock_loss_cnt=0
  - lock_lost=0
- PRESETn assertion at any point returns all of the above immediately (asynchronously). core_rst_n goes low without waiting for a clock.
- Both locks rise before edge 0 → locked is seen at edge SYNC_STAGES → STABILIZE is entered at edge SYNC_STAGES+1 → HOLD at SYNC_STAGES+1+LOCK_STABLE_CYCLES → RUN, with core_rst_n=1 and clk_ok=1, at SYNC_STAGES+1+LOCK_STABLE_CYCLES+RST_HOLD_CYCLES. With defaults this is edge 275.
- Lock falls before edge 0 while in RUN → core_rst_n and clk_ok go low at edge SYNC_STAGES+1. The counter updates on the same edge.
- sw_rst_req sampled at edge k in RUN → core_rst_n goes low at edge k and returns high at edge k+RST_HOLD_CYCLES.
- Lock pulses shorter than one PCLK period may be missed. Only the synchronized value is authoritative.

## Test plan
All scenarios use SYNC_STAGES=2, LOCK_STABLE_CYCLES=8, RST_HOLD_CYCLES=4, CNT_W=2.
- **Clean power-up:** release PRESETn, then raise both locks before edge 0 → state goes 0→1 at edge 3, 1→2 at edge 11, 2→3 at edge 15. core_rst_n=0 through edge 14 and 1 from edge 15. lock_loss_cnt stays 0.
- **Lock glitch during STABILIZE:** drop fab_lock for 3 cycles mid-STABILIZE → state returns to 0 and lock_loss_cnt stays 0. After re-lock, the full 8+4 sequence repeats from the start.
- **Lock loss in RUN, repeated:** 4 losses with re-lock between each → core_rst_n goes low 3 edges after each fall. lock_loss_cnt reads 1, 2, 3, 3 (saturated). lock_lost=1.
- **Software reset:** pulse sw_rst_req at edge k in RUN → core_rst_n is 0 for edges k..k+3 and 1 at k+4. State path is 3→2→3. Counters are unchanged.
- **Simultaneous events:** in one cycle, apply sw_rst_req, locked falling, and clr_status together → state goes to 0, lock_loss_cnt=1, lock_lost=1.
- **Reset mid-operation:** assert PRESETn low between edges during HOLD → core_rst_n, clk_ok, state, and the counters all read 0 before the next edge. Locks held high then give RUN 15 edges after PRESETn is released.
